// File: rtl/tlc_pkg.sv
// Shared encodings for the traffic-light sequencer: state codes, lamp patterns,
// counter width and the state-to-lamp decode.
package tlc_pkg;

   localparam int CNT_W = 5;

   typedef enum logic [2:0] {
      S_MG   = 3'd0,
      S_MY   = 3'd1,
      S_WALK = 3'd2,
      S_SG   = 3'd3,
      S_SY   = 3'd4
   } state_t;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   typedef struct packed {
      logic [2:0] main_lt;
      logic [2:0] side_lt;
      logic       walk;
   } lamps_t;

   // Unreachable codes show all-red so a corrupted state can never show a conflict.
   function automatic lamps_t lamp_decode(input state_t s);
      lamps_t l;
      l = '{main_lt: RED, side_lt: RED, walk: 1'b0};
      case (s)
         S_MG:    l.main_lt = GRN;
         S_MY:    l.main_lt = YEL;
         S_WALK:  l.walk    = 1'b1;
         S_SG:    l.side_lt = GRN;
         S_SY:    l.side_lt = YEL;
         default: ;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/tick_timer.sv
// Load / decrement / expire down-counter. Counts down on tick while above 1,
// holds at 1, and flags expiry on a tick seen while at 1.
module tick_timer
   import tlc_pkg::*;
#(
   parameter logic [CNT_W-1:0] RST_VAL = 5'd8
) (
   input  logic             clk,
   input  logic             WR_Reset,
   input  logic             tick,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire
);

   logic [CNT_W-1:0] count;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge WR_Reset) begin
      if (WR_Reset)
         count <= RST_VAL;
      else if (load)
         count <= load_val;
      else if (tick && (count > CNT_W'(1)))
         count <= count - CNT_W'(1);
   end

   assign expire = tick && (count == CNT_W'(1));

endmodule

// File: rtl/light_sequencer.sv
// Main/side street traffic-light sequencer with pedestrian WALK phase and a
// one-shot side-green extension. All outputs are registered decodes of the state.
module light_sequencer
   import tlc_pkg::*;
#(
   parameter int T_BASE = 8,
   parameter int T_YEL  = 2,
   parameter int T_EXT  = 4
) (
   input  logic       clk,
   input  logic       WR_Reset,
   input  logic       tick,
   input  logic       WR,
   input  logic       sensor,
   output logic [2:0] main_lt,
   output logic [2:0] side_lt,
   output logic       walk_lamp,
   output logic       wr_clear,
   output logic [2:0] state_o
);

   localparam logic [CNT_W-1:0] T_BASE_C = CNT_W'(T_BASE);
   localparam logic [CNT_W-1:0] T_YEL_C  = CNT_W'(T_YEL);
   localparam logic [CNT_W-1:0] T_EXT_C  = CNT_W'(T_EXT);

   state_t           state, next_state;
   logic             ext_used, ext_next;
   logic             load, expire;
   logic [CNT_W-1:0] load_val;
   lamps_t           lamps;
   logic             wr_clear_d;

   tick_timer #(.RST_VAL(T_BASE_C)) u_timer (
      .clk      (clk),
      .WR_Reset (WR_Reset),
      .tick     (tick),
      .load     (load),
      .load_val (load_val),
      .expire   (expire)
   );

   always_ff @(posedge clk or posedge WR_Reset) begin
      if (WR_Reset) begin
         state    <= S_MG;
         ext_used <= 1'b0;
      end else begin
         state    <= next_state;
         ext_used <= ext_next;
      end
   end

   // MG with no request leaves the timer parked at 1 until a request shows up on a tick.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path infers a latch.
      next_state = state;
      ext_next   = ext_used;
      load       = 1'b0;
      load_val   = T_BASE_C;
      case (state)
         S_MG: if (expire && (WR || sensor)) begin
            next_state = S_MY;
            load       = 1'b1;
            load_val   = T_YEL_C;
         end
         S_MY: if (expire) begin
            next_state = WR ? S_WALK : S_SG;
            load       = 1'b1;
            load_val   = T_EXT_C;
            ext_next   = 1'b0;
         end
         S_WALK: if (expire) begin
            next_state = sensor ? S_SG : S_MG;
            load       = 1'b1;
            load_val   = sensor ? T_EXT_C : T_BASE_C;
            ext_next   = 1'b0;
         end
         S_SG: if (expire) begin
            load = 1'b1;
            if (sensor && !ext_used) begin
               load_val = T_EXT_C;
               ext_next = 1'b1;
            end else begin
               next_state = S_SY;
               load_val   = T_YEL_C;
            end
         end
         S_SY: if (expire) begin
            next_state = S_MG;
            load       = 1'b1;
         end
         default: begin
            next_state = S_MG;
            load       = 1'b1;
            ext_next   = 1'b0;
         end
      endcase
   end

   // walk_lamp still low while state is WALK marks the first WALK cycle.
   always_comb begin
      lamps      = lamp_decode(state);
      wr_clear_d = (state == S_WALK) && !walk_lamp;
   end

   always_ff @(posedge clk or posedge WR_Reset) begin
      if (WR_Reset) begin
         main_lt   <= GRN;
         side_lt   <= RED;
         walk_lamp <= 1'b0;
         wr_clear  <= 1'b0;
         state_o   <= S_MG;
      end else begin
         main_lt   <= lamps.main_lt;
         side_lt   <= lamps.side_lt;
         walk_lamp <= lamps.walk;
         wr_clear  <= wr_clear_d;
         state_o   <= state;
      end
   end

endmodule

// File: tb/tb_light_sequencer.sv
// Self-checking bench: a tick-level reference model compared every cycle, plus
// directed scenarios with hand-computed tick counts.
module tb_light_sequencer;

   localparam int T_BASE = 8;
   localparam int T_YEL  = 2;
   localparam int T_EXT  = 4;
   localparam int MG = 0, MY = 1, WALK = 2, SG = 3, SY = 4;

   logic       clk = 1'b0;
   logic       WR_Reset, tick, WR, sensor;
   logic [2:0] main_lt, side_lt, state_o;
   logic       walk_lamp, wr_clear;

   int checks = 0;
   int errors = 0;
   bit run = 1'b0;
   int clr_cnt = 0;
   int n;

   light_sequencer #(.T_BASE(T_BASE), .T_YEL(T_YEL), .T_EXT(T_EXT)) dut (
      .clk       (clk),
      .WR_Reset  (WR_Reset),
      .tick      (tick),
      .WR        (WR),
      .sensor    (sensor),
      .main_lt   (main_lt),
      .side_lt   (side_lt),
      .walk_lamp (walk_lamp),
      .wr_clear  (wr_clear),
      .state_o   (state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: state plus remaining ticks; outputs show the previous cycle's state.
   function automatic int main_of(input int s);
      return (s == MG) ? 1 : (s == MY) ? 2 : 4;
   endfunction
   function automatic int side_of(input int s);
      return (s == SG) ? 1 : (s == SY) ? 2 : 4;
   endfunction

   int m_st, m_rem, m_age, nst;
   bit m_ext;
   int e_main, e_side, e_walk, e_clr, e_state;

   always @(posedge clk or posedge WR_Reset) begin
      if (WR_Reset) begin
         m_st = MG; m_rem = T_BASE; m_ext = 1'b0; m_age = 0;
         e_main = 1; e_side = 4; e_walk = 0; e_clr = 0; e_state = MG;
      end else begin
         e_main  = main_of(m_st);
         e_side  = side_of(m_st);
         e_walk  = (m_st == WALK) ? 1 : 0;
         e_clr   = (m_st == WALK && m_age == 0) ? 1 : 0;
         e_state = m_st;
         nst = m_st;
         if (tick) begin
            if (m_rem > 1) m_rem--;
            else begin
               case (m_st)
                  MG:   if (WR || sensor) begin nst = MY; m_rem = T_YEL; end
                  MY:   begin nst = WR ? WALK : SG; m_rem = T_EXT; m_ext = 1'b0; end
                  WALK: begin nst = sensor ? SG : MG; m_rem = sensor ? T_EXT : T_BASE; m_ext = 1'b0; end
                  SG:   if (sensor && !m_ext) begin m_rem = T_EXT; m_ext = 1'b1; end
                        else begin nst = SY; m_rem = T_YEL; end
                  default: begin nst = MG; m_rem = T_BASE; end
               endcase
            end
         end
         if (nst != m_st) begin m_st = nst; m_age = 0; end
         else m_age++;
      end
   end

   always @(negedge clk) begin
      if (run) begin
         check("main_lt", int'(main_lt), e_main);
         check("side_lt", int'(side_lt), e_side);
         check("walk_lamp", int'(walk_lamp), e_walk);
         check("wr_clear", int'(wr_clear), e_clr);
         check("state_o", int'(state_o), e_state);
         check("no_overlap", int'(main_lt != 3'b100 && side_lt != 3'b100), 0);
         check("walk_both_red", int'(walk_lamp && !(main_lt == 3'b100 && side_lt == 3'b100)), 0);
      end
      if (wr_clear) clr_cnt++;
   end

   // Issue single-tick pulses until state_o shows target or limit ticks elapse.
   task automatic ticks_until(input int target, input int limit, output int cnt);
      cnt = 0;
      while (int'(state_o) != target && cnt < limit) begin
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
         @(negedge clk);
         @(negedge clk);
         cnt++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      WR_Reset = 1'b1;
      @(negedge clk);
      WR_Reset = 1'b0;
   endtask

   initial begin
      WR_Reset = 1'b1; tick = 1'b0; WR = 1'b0; sensor = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_main", int'(main_lt), 1);
      check("rst_side", int'(side_lt), 4);
      check("rst_walk", int'(walk_lamp), 0);
      check("rst_clr", int'(wr_clear), 0);
      check("rst_state", int'(state_o), MG);
      WR_Reset = 1'b0;
      run = 1'b1;

      // Idle: 20 ticks with no requests stays in MG.
      ticks_until(MY, 20, n);
      check("idle_ticks", n, 20);
      check("idle_state", int'(state_o), MG);
      check("idle_main", int'(main_lt), 1);

      // Walk request: 8 ticks MG, 2 ticks MY, 4 ticks WALK, back to MG.
      do_reset();
      WR = 1'b1; clr_cnt = 0;
      ticks_until(MY, 20, n);   check("walk_mg_ticks", n, 8);
      ticks_until(WALK, 20, n); check("walk_my_ticks", n, 2);
      WR = 1'b0;
      check("walk_lamp_on", int'(walk_lamp), 1);
      ticks_until(MG, 20, n);   check("walk_ticks", n, 4);
      check("walk_clr_pulses", clr_cnt, 1);

      // Sensor held: MG 8, MY 2, SG 4+4, SY 2.
      do_reset();
      sensor = 1'b1;
      ticks_until(MY, 20, n); check("sen_mg_ticks", n, 8);
      ticks_until(SG, 20, n); check("sen_my_ticks", n, 2);
      ticks_until(SY, 20, n); check("sen_sg_ticks", n, 8);
      ticks_until(MG, 20, n); check("sen_sy_ticks", n, 2);
      sensor = 1'b0;

      // WR and sensor together: WALK first, then SG; WR re-raised in WALK waits for next MG.
      do_reset();
      WR = 1'b1; sensor = 1'b1;
      ticks_until(MY, 20, n);   check("both_mg_ticks", n, 8);
      ticks_until(WALK, 20, n); check("both_my_ticks", n, 2);
      check("both_walk_main", int'(main_lt), 4);
      check("both_walk_side", int'(side_lt), 4);
      WR = 1'b0;
      @(negedge clk);
      WR = 1'b1;
      ticks_until(SG, 20, n);   check("both_walk_ticks", n, 4);
      sensor = 1'b0;
      ticks_until(SY, 20, n);   check("both_sg_ticks", n, 4);
      ticks_until(MG, 20, n);   check("both_sy_ticks", n, 2);
      ticks_until(MY, 20, n);   check("held_wr_mg_ticks", n, 8);
      ticks_until(WALK, 20, n); check("held_wr_my_ticks", n, 2);

      // Reset mid-WALK: lamps return to MG immediately, next exit needs 8 ticks.
      tick = 1'b1; @(negedge clk); tick = 1'b0; @(negedge clk);
      #2 WR_Reset = 1'b1;
      #1;
      check("mid_rst_main", int'(main_lt), 1);
      check("mid_rst_side", int'(side_lt), 4);
      check("mid_rst_walk", int'(walk_lamp), 0);
      check("mid_rst_clr", int'(wr_clear), 0);
      check("mid_rst_state", int'(state_o), MG);
      @(negedge clk);
      @(negedge clk);
      WR_Reset = 1'b0;
      ticks_until(MY, 20, n);   check("post_rst_ticks", n, 8);

      // Tick starved in MY for 100 clocks: frozen, then one remaining tick.
      WR = 1'b0;
      tick = 1'b1; @(negedge clk); tick = 1'b0; @(negedge clk);
      repeat (100) @(negedge clk);
      check("frozen_state", int'(state_o), MY);
      ticks_until(SG, 5, n);    check("frozen_resume_ticks", n, 1);

      run = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/light_sequencer.md
LIGHT_SEQUENCER -- requirements
Module: light_sequencer

Interface
REQ-001 SHALL have parameter T_BASE, 8, minimum main-green time in ticks (legal 1..31).
REQ-002 SHALL have parameter T_YEL, 2, yellow time in ticks (legal 1..31).
REQ-003 SHALL have parameter T_EXT, 4, walk time, side-green time and side-green extension in ticks (legal 1..31).
REQ-004 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port WR_Reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port tick  input  1  one-clk timing strobe; timers advance only when high.
REQ-007 SHALL have port WR  input  1  latched pedestrian walk request, level.
REQ-008 SHALL have port sensor  input  1  side-street vehicle present, level, pre-synchronised.
REQ-009 SHALL have port main_lt  output  3  main-street lamps {R,Y,G}, one-hot.
REQ-010 SHALL have port side_lt  output  3  side-street lamps {R,Y,G}, one-hot.
REQ-011 SHALL have port walk_lamp  output  1  pedestrian WALK indicator.
REQ-012 SHALL have port wr_clear  output  1  one-clk pulse clearing the walk-request register.
REQ-013 SHALL have port state_o  output  3  current state code, for debug.

Function
REQ-014 SHALL implement a Moore FSM with states MG, MY, WALK, SG, SY; every output registered and decoded from state only.
REQ-015 SHALL keep a 5-bit down-counter loaded with the new state's duration on each state entry; it decrements on each clk with tick=1 while its value is >1.
REQ-016 SHALL take a timed transition on the clk edge where tick=1 and counter=1; no transition occurs without tick.
REQ-017 MG (main G, side R): on expiry, if WR=1 or sensor=1 go to MY; otherwise remain in MG with counter held at 1, leaving on the first tick on which WR or sensor is high.
REQ-018 MY (main Y, side R), duration T_YEL: on expiry, go to WALK if WR=1, else SG.
REQ-019 WALK (both R, walk_lamp=1), duration T_EXT: wr_clear SHALL be high for exactly the first clk of WALK; on expiry, go to SG if sensor=1, else MG.
REQ-020 SG (main R, side G), duration T_EXT: on expiry with sensor=1 and no extension used in this SG visit, reload T_EXT once; otherwise go to SY.
REQ-021 SY (main R, side Y), duration T_YEL: on expiry, go to MG.
REQ-022 SHALL give WR priority over sensor when both are high at MG expiry: MG->MY->WALK, then SG if sensor is still high.
REQ-023 A WR asserted during WALK after wr_clear SHALL be retained externally and served on the next MG expiry; the sequencer SHALL NOT re-enter WALK directly.
REQ-024 SHALL never drive green or yellow on both streets at once; walk_lamp=1 only when both streets are R.
REQ-025 An unreachable state encoding SHALL go to MG on the next clk with the counter loaded with T_BASE.
REQ-026 MG duration SHALL be T_BASE; the state change and counter reload occur on the same clk edge; outputs reflect the new state in the following cycle.

Reset
REQ-027 WR_Reset=1 SHALL immediately force state MG, counter=T_BASE, extension flag=0, main_lt=001 (G), side_lt=100 (R), walk_lamp=0, wr_clear=0, state_o=MG code.
REQ-028 Reset asserted mid-WALK SHALL drop walk_lamp and wr_clear at once; WR is not cleared by this block.
REQ-029 After reset release, the first timed transition SHALL require T_BASE ticks.

Structure
REQ-030 Package tlc_pkg SHALL hold the state encoding (MG=0, MY=1, WALK=2, SG=3, SY=4), lamp constants (RED=100, YEL=010, GRN=001) and counter width.
REQ-031 Sub-module tick_timer (5-bit load/decrement/expire counter) SHALL be instantiated once; FSM and output decode stay in light_sequencer.

Verification
REQ-032 Reset, then 20 ticks with WR=0 and sensor=0 -> stays MG, main_lt=001, side_lt=100.
REQ-033 WR=1 before tick 8 (default params) -> MY after tick 8, WALK after tick 10, wr_clear high 1 clk, walk_lamp high for 4 ticks, then MG.
REQ-034 sensor=1 held -> MG(8)->MY(2)->SG(4+4 extended)->SY(2)->MG; no second extension.
REQ-035 WR=1 and sensor=1 together at MG expiry -> MY->WALK->SG; both-red interval during WALK, no green overlap.
REQ-036 WR_Reset pulse mid-WALK -> same-cycle MG lamps, walk_lamp=0, wr_clear=0; next transition requires 8 ticks.
REQ-037 tick held low for 100 clks in MY -> no state change, counter frozen.
